mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences one shared single-port memory bus between the CPU's instruction-fetch requester and its data load/store requester.
- Sits between the request unit and the memory/bus interface.
- Grants one transaction at a time, registers address and write data, drives the bus strobes and returns the read data.
- Signals completion per requester, alternates priority to prevent starvation, and aborts hung bus cycles with a timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max consecutive busy cycles before abort (1..2^CNT_W-1)
CNT_W, 8, timeout counter width

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, synchronous, active-low
i_req  in  1  instruction fetch request; held until i_ready
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetched instruction, valid while i_ready=1
i_ready  out  1  one-cycle completion pulse, fetch
d_ren  in  1  data read request; held until d_ready
d_wen  in  1  data write request; held until d_ready
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid while d_ready=1
d_ready  out  1  one-cycle completion pulse, data
mem_ren  out  1  bus read strobe
mem_wen  out  1  bus write strobe
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_rdata  in  DATA_W  bus read data, sampled at completion edge
mem_busy  in  1  bus not done; completion = strobe high and mem_busy low at a rising edge
bus_err  out  1  one-cycle pulse with the ready of an aborted transaction

Behaviour:
- Reset (nRST=0 at edge):
  - State IDLE; all outputs 0; last_d=0; timeout counter 0.
  - Applied mid-transaction: strobes drop at that edge; no ready is issued.
- States: IDLE, I_ACC, D_ACC. All outputs are registered.
- IDLE arbitration, per cycle:
  - d_pend = (d_ren|d_wen) & !d_ready
  - i_pend = i_req & !i_ready
  - Requester whose ready is high this cycle is masked.
  - Both pending: grant D unless last_d=1, in which case grant I.
  - Only one pending: grant it. None pending: stay IDLE.
- On grant edge:
  - Latch address (and d_wdata for D) into mem_addr/mem_wdata.
  - Set mem_ren (I, or D read) or mem_wen (D write); d_wen=d_ren=1 is treated as a write.
  - Set last_d = (grant==D); clear counter; go to I_ACC/D_ACC.
- *_ACC states:
  - Strobes, address and wdata held stable.
  - mem_busy=0 at an edge: completion.
    - Strobes drop; return to IDLE.
    - Granted requester's ready=1 for exactly the next cycle; rdata=mem_rdata for reads, 0 for writes.
  - mem_busy=1: counter increments. Counter reaches TIMEOUT while mem_busy=1: abort.
    - Strobes drop; return to IDLE.
    - Ready pulse with rdata=0 and bus_err=1 in the same cycle.
- Latency:
  - Zero-wait bus: request in IDLE cycle 0 -> strobe cycle 1 -> ready cycle 2.
  - Each busy cycle adds 1.
- Ready cycle (state IDLE): the other requester may be granted at its end. The completed requester can be re-granted no earlier than the following cycle.
- Requester dropping its request mid-transaction: ignored; transaction completes and ready still pulses.
- Inputs changing mid-transaction: no effect (latched).
- i_ready and d_ready are never high in the same cycle. At most one strobe is high at any time.
- rdata outputs return to 0 when their ready is low.

Test Plan:
- Reset then idle: nRST=0 2 cycles, no requests -> all outputs 0, state IDLE, no strobes for 10 cycles.
- Zero-wait fetch: i_req=1, i_addr=0x0000_0100, mem_busy=0, mem_rdata=0x0000_0013 -> mem_ren=1 with mem_addr=0x100 in cycle 1; i_ready=1, i_rdata=0x13 in cycle 2; then d_ready=0 and bus_err=0.
- Write with waits: d_wen=1, d_addr=0x2000, d_wdata=0xDEADBEEF, mem_busy=1 for 3 strobe cycles -> mem_wen high 4 cycles with stable addr/data; d_ready=1, d_rdata=0 in cycle 5.
- Contention/fairness: i_req and d_ren held continuously, zero-wait bus -> grants in order D, I, D, I; neither requester waits more than one transaction.
- Timeout: TIMEOUT=4, d_ren=1, mem_busy stuck 1 -> mem_ren high 4 cycles then 0; d_ready=1, bus_err=1, d_rdata=0 for one cycle; next i_req is granted normally.
- Reset mid-access: nRST=0 during D_ACC with mem_busy=1 -> mem_ren/mem_wen=0 after that edge; no d_ready/bus_err pulse after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory bus between the instruction-fetch
// requester and the data load/store requester. One transaction at a time.
// Priority alternates when both requesters are pending, and a bus cycle that
// stays busy for TIMEOUT cycles is aborted with bus_err.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no bus cycle; arbitrate and grant; ready pulses occur here
//  I_ACC | fetch read on the bus, waiting for mem_busy low or timeout
//  D_ACC | data read/write on the bus, waiting for mem_busy low or timeout
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_busy,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_t;

    // Abort fires on the busy edge that would bring the count to TIMEOUT.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_t            r_state;
    logic              r_mem_ren;
    logic              r_mem_wen;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_i_ready;
    logic              r_d_ready;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_bus_err;
    logic              r_last_d;
    logic [CNT_W-1:0]  r_cnt;

    state_t            w_state_nxt;
    logic              w_mem_ren_nxt;
    logic              w_mem_wen_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              w_i_ready_nxt;
    logic              w_d_ready_nxt;
    logic [DATA_W-1:0] w_i_rdata_nxt;
    logic [DATA_W-1:0] w_d_rdata_nxt;
    logic              w_bus_err_nxt;
    logic              w_last_d_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    logic              w_i_pend;
    logic              w_d_pend;
    logic              w_grant_d;
    logic              w_end;
    logic              w_abort;
    logic [DATA_W-1:0] w_ret_data;

    // A requester whose ready is high this cycle is masked, so it cannot be
    // re-granted on the strength of a request it has not yet dropped.
    assign w_i_pend   = i_req & ~r_i_ready;
    assign w_d_pend   = (d_ren | d_wen) & ~r_d_ready;
    assign w_grant_d  = w_d_pend & (~w_i_pend | ~r_last_d);
    assign w_abort    = mem_busy & (r_cnt == TMO_LAST);
    assign w_end      = ~mem_busy | w_abort;
    assign w_ret_data = (r_mem_ren & ~mem_busy) ? mem_rdata : '0;

    // Next-state, bus strobes, completion pulses and timeout counter.
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_ren_nxt   = r_mem_ren;
        w_mem_wen_nxt   = r_mem_wen;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_i_ready_nxt   = 1'b0;
        w_d_ready_nxt   = 1'b0;
        w_i_rdata_nxt   = '0;
        w_d_rdata_nxt   = '0;
        w_bus_err_nxt   = 1'b0;
        w_last_d_nxt    = r_last_d;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt     = D_ACC;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                    // read+write together is taken as a write
                    w_mem_wen_nxt   = d_wen;
                    w_mem_ren_nxt   = ~d_wen;
                    w_last_d_nxt    = 1'b1;
                    w_cnt_nxt       = '0;
                end else if (w_i_pend) begin
                    w_state_nxt     = I_ACC;
                    w_mem_addr_nxt  = i_addr;
                    w_mem_wdata_nxt = '0;
                    w_mem_wen_nxt   = 1'b0;
                    w_mem_ren_nxt   = 1'b1;
                    w_last_d_nxt    = 1'b0;
                    w_cnt_nxt       = '0;
                end
            end
            I_ACC, D_ACC: begin
                if (w_end) begin
                    w_state_nxt     = IDLE;
                    w_mem_ren_nxt   = 1'b0;
                    w_mem_wen_nxt   = 1'b0;
                    w_mem_addr_nxt  = '0;
                    w_mem_wdata_nxt = '0;
                    w_bus_err_nxt   = w_abort;
                    if (r_state == D_ACC) begin
                        w_d_ready_nxt = 1'b1;
                        w_d_rdata_nxt = w_ret_data;
                    end else begin
                        w_i_ready_nxt = 1'b1;
                        w_i_rdata_nxt = w_ret_data;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_ren_nxt = 1'b0;
                w_mem_wen_nxt = 1'b0;
            end
        endcase
    end

    // Register every output; synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state     <= IDLE;
            r_mem_ren   <= 1'b0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_ready   <= 1'b0;
            r_d_ready   <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_bus_err   <= 1'b0;
            r_last_d    <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_mem_ren   <= w_mem_ren_nxt;
            r_mem_wen   <= w_mem_wen_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_i_ready   <= w_i_ready_nxt;
            r_d_ready   <= w_d_ready_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_last_d    <= w_last_d_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    assign mem_ren   = r_mem_ren;
    assign mem_wen   = r_mem_wen;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_ready   = r_i_ready;
    assign d_ready   = r_d_ready;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int TMO = 4;

    logic        CLK;
    logic        nRST;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busy;
    logic        bus_err;

    int n_checks = 0;
    int n_err    = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .CNT_W(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy),
        .bus_err(bus_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(negedge CLK);
    endtask

    // Transaction-level model: one outstanding transaction, counted busy
    // edges, alternating priority; produces the expected outputs per cycle.
    logic        e_ren, e_wen, e_i_ready, e_d_ready, e_err;
    logic [31:0] e_addr, e_wdata, e_i_rdata, e_d_rdata;
    bit          m_valid = 0;
    bit          t_act, t_is_d, t_write, last_d, ip, dp, gd;
    int          waited;
    logic [31:0] ret;

    initial begin
        e_ren = 0; e_wen = 0; e_i_ready = 0; e_d_ready = 0; e_err = 0;
        e_addr = 0; e_wdata = 0; e_i_rdata = 0; e_d_rdata = 0;
        t_act = 0; t_is_d = 0; t_write = 0; last_d = 0; waited = 0;
        forever begin
            @(posedge CLK);
            if (!nRST) begin
                t_act = 0; last_d = 0; waited = 0;
                e_i_ready = 0; e_d_ready = 0; e_err = 0;
                e_i_rdata = 0; e_d_rdata = 0;
                m_valid = 1;
            end else begin
                ip = i_req && !e_i_ready;
                dp = (d_ren || d_wen) && !e_d_ready;
                e_i_ready = 0; e_d_ready = 0; e_err = 0;
                e_i_rdata = 0; e_d_rdata = 0;
                if (!t_act) begin
                    if (ip || dp) begin
                        gd      = dp && (!ip || !last_d);
                        t_act   = 1;
                        t_is_d  = gd;
                        t_write = gd && d_wen;
                        e_addr  = gd ? d_addr : i_addr;
                        e_wdata = d_wdata;
                        waited  = 0;
                        last_d  = gd;
                    end
                end else if (!mem_busy || waited + 1 == TMO) begin
                    ret   = (mem_busy || t_write) ? 32'h0 : mem_rdata;
                    e_err = mem_busy;
                    if (t_is_d) begin
                        e_d_ready = 1; e_d_rdata = ret;
                    end else begin
                        e_i_ready = 1; e_i_rdata = ret;
                    end
                    t_act = 0;
                end else begin
                    waited++;
                end
            end
            e_ren = t_act && !t_write;
            e_wen = t_act && t_write;
        end
    end

    // Compare process: DUT outputs against the model, every cycle after reset.
    initial begin
        forever begin
            @(negedge CLK);
            if (m_valid) begin
                chk("m_i_ready", 32'(i_ready), 32'(e_i_ready));
                chk("m_d_ready", 32'(d_ready), 32'(e_d_ready));
                chk("m_bus_err", 32'(bus_err), 32'(e_err));
                chk("m_i_rdata", i_rdata, e_i_rdata);
                chk("m_d_rdata", d_rdata, e_d_rdata);
                chk("m_mem_ren", 32'(mem_ren), 32'(e_ren));
                chk("m_mem_wen", 32'(mem_wen), 32'(e_wen));
                if (e_ren || e_wen) chk("m_mem_addr", mem_addr, e_addr);
                if (e_wen) chk("m_mem_wdata", mem_wdata, e_wdata);
                chk("m_one_ready", 32'(i_ready & d_ready), 32'd0);
                chk("m_one_strobe", 32'(mem_ren & mem_wen), 32'd0);
            end
        end
    end

    logic [31:0] cont_addr [4];

    initial begin
        nRST = 0; i_req = 0; i_addr = 0; d_ren = 0; d_wen = 0;
        d_addr = 0; d_wdata = 0; mem_rdata = 0; mem_busy = 0;

        // reset then idle
        tick; tick;
        nRST = 1;
        for (int k = 0; k < 10; k++) begin
            tick;
            chk("idle_ren", 32'(mem_ren), 32'd0);
            chk("idle_wen", 32'(mem_wen), 32'd0);
            chk("idle_ready", 32'({i_ready, d_ready, bus_err}), 32'd0);
        end

        // write with three wait cycles; inputs scrambled mid-transaction
        d_wen = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; mem_busy = 1;
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk("wr_wen", 32'(mem_wen), 32'd1);
            chk("wr_addr", mem_addr, 32'h2000);
            chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
            d_addr = $urandom; d_wdata = $urandom;
            if (k == 4) mem_busy = 0;
        end
        tick;
        chk("wr_ready", 32'(d_ready), 32'd1);
        chk("wr_rdata", d_rdata, 32'h0);
        chk("wr_wen_off", 32'(mem_wen), 32'd0);
        d_wen = 0;
        tick;

        // zero-wait fetch
        i_req = 1; i_addr = 32'h100; mem_busy = 0; mem_rdata = 32'h13;
        tick;
        chk("fe_ren", 32'(mem_ren), 32'd1);
        chk("fe_addr", mem_addr, 32'h100);
        tick;
        chk("fe_ready", 32'(i_ready), 32'd1);
        chk("fe_rdata", i_rdata, 32'h13);
        chk("fe_model_rdata", e_i_rdata, 32'h13);
        chk("fe_d_ready", 32'(d_ready), 32'd0);
        chk("fe_err", 32'(bus_err), 32'd0);
        i_req = 0;
        tick;

        // contention: both held, grants alternate D, I, D, I
        cont_addr = '{32'h800, 32'h400, 32'h800, 32'h400};
        i_req = 1; i_addr = 32'h400; d_ren = 1; d_addr = 32'h800;
        mem_rdata = 32'h55;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (c % 2 == 1) begin
                chk("ct_ren", 32'(mem_ren), 32'd1);
                chk("ct_addr", mem_addr, cont_addr[(c - 1) / 2]);
            end else if (c % 4 == 2) begin
                chk("ct_d_ready", 32'(d_ready), 32'd1);
                chk("ct_model_d", 32'(e_d_ready), 32'd1);
            end else begin
                chk("ct_i_ready", 32'(i_ready), 32'd1);
            end
        end
        i_req = 0; d_ren = 0;
        tick;

        // timeout abort, then a normal fetch
        d_ren = 1; d_addr = 32'h3000; mem_busy = 1; mem_rdata = 32'hA5A5A5A5;
        for (int k = 1; k <= 4; k++) begin
            tick;
            chk("to_ren", 32'(mem_ren), 32'd1);
        end
        tick;
        chk("to_ren_off", 32'(mem_ren), 32'd0);
        chk("to_ready", 32'(d_ready), 32'd1);
        chk("to_err", 32'(bus_err), 32'd1);
        chk("to_rdata", d_rdata, 32'h0);
        d_ren = 0; i_req = 1; i_addr = 32'h500; mem_busy = 0;
        tick;
        chk("to_next_ren", 32'(mem_ren), 32'd1);
        chk("to_next_addr", mem_addr, 32'h500);
        tick;
        chk("to_next_ready", 32'(i_ready), 32'd1);
        chk("to_next_err", 32'(bus_err), 32'd0);
        chk("to_next_rdata", i_rdata, 32'hA5A5A5A5);
        i_req = 0;
        tick;

        // reset during a busy data read
        d_ren = 1; d_addr = 32'h600; mem_busy = 1;
        tick;
        chk("rs_ren", 32'(mem_ren), 32'd1);
        tick;
        nRST = 0;
        tick;
        chk("rs_ren_off", 32'(mem_ren), 32'd0);
        chk("rs_wen_off", 32'(mem_wen), 32'd0);
        nRST = 1; d_ren = 0; mem_busy = 0;
        for (int k = 0; k < 6; k++) begin
            tick;
            chk("rs_no_ready", 32'(d_ready), 32'd0);
            chk("rs_no_err", 32'(bus_err), 32'd0);
        end

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick;
            nRST = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) i_req = ~i_req;
            if ($urandom_range(0, 3) == 0) begin
                d_ren = 1'($urandom_range(0, 1));
                d_wen = 1'($urandom_range(0, 1));
            end
            i_addr    = $urandom;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            mem_rdata = $urandom;
            mem_busy  = ($urandom_range(0, 9) < 6);
        end
        tick;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
